// File: rtl/motion_bbox_detect_if.sv
// motion_bbox_detect_if
//   Binary motion-mask stream from the frame-difference stage.
//   diff_data_vsync : frame sync, high during vertical blank
//   diff_data_href  : line valid, high on active pixels
//   diff_data       : mask pixel, any nonzero value marks motion
//   master drives the stream, slave (the detector) consumes it.
interface motion_bbox_detect_if;
   logic        diff_data_vsync;
   logic        diff_data_href;
   logic [15:0] diff_data;

   modport master (output diff_data_vsync, output diff_data_href, output diff_data);
   modport slave  (input  diff_data_vsync, input  diff_data_href, input  diff_data);
endinterface

// File: rtl/motion_bbox_detect.sv
// motion_bbox_detect
//   Per frame, counts motion pixels in the binary mask and tracks the min/max
//   column and row at which they occur. On each frame boundary (vsync rising)
//   the bounding box, pixel count and motion flag are published together with
//   a one-cycle bbox_valid pulse. The partial frame seen after reset is dropped.
// Ports
//   clk              : pixel clock
//   rst_n            : asynchronous reset, active low
//   in_if            : mask stream (vsync / href / data), slave side
//   bbox_valid       : one-cycle pulse, results below were just updated
//   motion_detected  : last complete frame had at least MIN_PIXELS motion pixels
//   bbox_x_min/max   : leftmost / rightmost motion column (0 when no motion)
//   bbox_y_min/max   : top / bottom motion row (0 when no motion)
//   motion_pixel_cnt : motion pixels in last complete frame, saturating
module motion_bbox_detect #(
   parameter int H_W        = 11,
   parameter int V_W        = 11,
   parameter int CNT_W      = 21,
   parameter int MIN_PIXELS = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   motion_bbox_detect_if.slave  in_if,
   output logic                 bbox_valid,
   output logic                 motion_detected,
   output logic [H_W-1:0]       bbox_x_min,
   output logic [H_W-1:0]       bbox_x_max,
   output logic [V_W-1:0]       bbox_y_min,
   output logic [V_W-1:0]       bbox_y_max,
   output logic [CNT_W-1:0]     motion_pixel_cnt
);

   function automatic logic [H_W-1:0] sat_inc_h(input logic [H_W-1:0] v);
      return (&v) ? v : v + H_W'(1);
   endfunction

   function automatic logic [V_W-1:0] sat_inc_v(input logic [V_W-1:0] v);
      return (&v) ? v : v + V_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic             vs_d;
   logic             hr_d;
   logic [H_W-1:0]   x;
   logic [V_W-1:0]   y;
   logic [H_W-1:0]   xmin;
   logic [H_W-1:0]   xmax;
   logic [V_W-1:0]   ymin;
   logic [V_W-1:0]   ymax;
   logic [CNT_W-1:0] cnt;
   logic             frame_seen;

   logic vs_rise;
   logic hr_fall;
   logic motion_pix;
   logic thresh_met;

   // Line ends during vertical blank must not advance the row counter.
   assign vs_rise    = in_if.diff_data_vsync & ~vs_d;
   assign hr_fall    = ~in_if.diff_data_href & hr_d & ~in_if.diff_data_vsync;
   assign motion_pix = in_if.diff_data_href & ~in_if.diff_data_vsync & (|in_if.diff_data);
   assign thresh_met = (cnt >= CNT_W'(MIN_PIXELS));

   // Stage: sync delay and pixel coordinates (x/y describe the pixel on the current edge)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d <= 1'b0;
         hr_d <= 1'b0;
         x    <= '0;
         y    <= '0;
      end else begin
         vs_d <= in_if.diff_data_vsync;
         hr_d <= in_if.diff_data_href;
         if (in_if.diff_data_href)
            x <= sat_inc_h(x);
         else
            x <= '0;
         if (vs_rise)
            y <= '0;
         else if (hr_fall)
            y <= sat_inc_v(y);
      end
   end

   // Stage: per-frame accumulators, cleared on the frame-closing edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xmin <= '1;
         xmax <= '0;
         ymin <= '1;
         ymax <= '0;
         cnt  <= '0;
      end else if (vs_rise) begin
         xmin <= '1;
         xmax <= '0;
         ymin <= '1;
         ymax <= '0;
         cnt  <= '0;
      end else if (motion_pix) begin
         if (x < xmin) xmin <= x;
         if (x > xmax) xmax <= x;
         if (y < ymin) ymin <= y;
         if (y > ymax) ymax <= y;
         cnt <= sat_inc_cnt(cnt);
      end
   end

   // Stage: result registers, loaded at frame close once a full frame has been seen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_seen       <= 1'b0;
         bbox_valid       <= 1'b0;
         motion_detected  <= 1'b0;
         bbox_x_min       <= '0;
         bbox_x_max       <= '0;
         bbox_y_min       <= '0;
         bbox_y_max       <= '0;
         motion_pixel_cnt <= '0;
      end else begin
         frame_seen <= frame_seen | vs_rise;
         bbox_valid <= vs_rise & frame_seen;
         if (vs_rise && frame_seen) begin
            motion_detected  <= thresh_met;
            motion_pixel_cnt <= cnt;
            // Below threshold the box is suppressed but the count is still reported.
            bbox_x_min       <= thresh_met ? xmin : '0;
            bbox_x_max       <= thresh_met ? xmax : '0;
            bbox_y_min       <= thresh_met ? ymin : '0;
            bbox_y_max       <= thresh_met ? ymax : '0;
         end
      end
   end

endmodule

// File: tb/tb_motion_bbox_detect.sv
// tb_motion_bbox_detect
//   Directed bench for motion_bbox_detect. Three instances share one mask
//   stream: MIN_PIXELS=1, MIN_PIXELS=4, and a narrow H_W=3 variant for
//   column saturation.
module tb_motion_bbox_detect;

   logic clk;
   logic rst_n;

   motion_bbox_detect_if vif ();

   // Instance a: MIN_PIXELS = 1
   logic        bv_a, md_a;
   logic [10:0] xmin_a, xmax_a, ymin_a, ymax_a;
   logic [20:0] cnt_a;
   // Instance b: MIN_PIXELS = 4
   logic        bv_b, md_b;
   logic [10:0] xmin_b, xmax_b, ymin_b, ymax_b;
   logic [20:0] cnt_b;
   // Instance c: H_W = 3, MIN_PIXELS = 1
   logic        bv_c, md_c;
   logic [2:0]  xmin_c, xmax_c;
   logic [10:0] ymin_c, ymax_c;
   logic [20:0] cnt_c;

   motion_bbox_detect #(.H_W(11), .V_W(11), .CNT_W(21), .MIN_PIXELS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_if(vif.slave),
      .bbox_valid(bv_a), .motion_detected(md_a),
      .bbox_x_min(xmin_a), .bbox_x_max(xmax_a),
      .bbox_y_min(ymin_a), .bbox_y_max(ymax_a),
      .motion_pixel_cnt(cnt_a));

   motion_bbox_detect #(.H_W(11), .V_W(11), .CNT_W(21), .MIN_PIXELS(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_if(vif.slave),
      .bbox_valid(bv_b), .motion_detected(md_b),
      .bbox_x_min(xmin_b), .bbox_x_max(xmax_b),
      .bbox_y_min(ymin_b), .bbox_y_max(ymax_b),
      .motion_pixel_cnt(cnt_b));

   motion_bbox_detect #(.H_W(3), .V_W(11), .CNT_W(21), .MIN_PIXELS(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_if(vif.slave),
      .bbox_valid(bv_c), .motion_detected(md_c),
      .bbox_x_min(xmin_c), .bbox_x_max(xmax_c),
      .bbox_y_min(ymin_c), .bbox_y_max(ymax_c),
      .motion_pixel_cnt(cnt_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] mask [0:3][0:15];

   // bbox_valid of each instance sampled just after the frame-closing edge,
   // and instance a one cycle later.
   logic pv_a, pv_b, pv_c, pv_a_next;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mask();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 16; c++)
            mask[r][c] = 16'h0000;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vif.diff_data_href = 1'b0;
         vif.diff_data      = 16'h0000;
      end
   endtask

   // Active frame of h lines, w pixels each, data taken from mask.
   task automatic send_frame(input int w, input int h);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            @(negedge clk);
            vif.diff_data_href = 1'b1;
            vif.diff_data      = mask[r][c];
         end
         idle(2);
      end
   endtask

   // Vertical blank: raises vsync (frame close), optionally pulses href with
   // 0xffff while vsync is high, then drops vsync again.
   task automatic vblank(input bit noisy);
      @(negedge clk);
      vif.diff_data_vsync = 1'b1;
      vif.diff_data_href  = 1'b0;
      vif.diff_data       = 16'h0000;
      @(negedge clk);
      pv_a = bv_a;
      pv_b = bv_b;
      pv_c = bv_c;
      @(negedge clk);
      pv_a_next = bv_a;
      if (noisy) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               vif.diff_data_href = 1'b1;
               vif.diff_data      = 16'hffff;
            end
            idle(2);
         end
      end
      idle(2);
      @(negedge clk);
      vif.diff_data_vsync = 1'b0;
      idle(1);
   endtask

   initial begin
      rst_n               = 1'b0;
      vif.diff_data_vsync = 1'b0;
      vif.diff_data_href  = 1'b0;
      vif.diff_data       = 16'h0000;
      clear_mask();
      repeat (3) @(negedge clk);

      check_eq("rst_valid",  32'(bv_a),   32'd0);
      check_eq("rst_md",     32'(md_a),   32'd0);
      check_eq("rst_xmin",   32'(xmin_a), 32'd0);
      check_eq("rst_xmax",   32'(xmax_a), 32'd0);
      check_eq("rst_ymin",   32'(ymin_a), 32'd0);
      check_eq("rst_cnt",    32'(cnt_a),  32'd0);

      rst_n = 1'b1;
      idle(3);

      // Test 1: first frame close only arms; empty frame reports zeros
      vblank(1'b0);
      check_eq("t1_first_no_pulse", 32'(pv_a), 32'd0);
      send_frame(8, 4);
      vblank(1'b0);
      check_eq("t1_pulse",  32'(pv_a),   32'd1);
      check_eq("t1_md",     32'(md_a),   32'd0);
      check_eq("t1_cnt",    32'(cnt_a),  32'd0);
      check_eq("t1_xmin",   32'(xmin_a), 32'd0);
      check_eq("t1_xmax",   32'(xmax_a), 32'd0);
      check_eq("t1_ymin",   32'(ymin_a), 32'd0);
      check_eq("t1_ymax",   32'(ymax_a), 32'd0);

      // Test 2: single motion pixel at (5,2)
      clear_mask();
      mask[2][5] = 16'h8000;
      send_frame(8, 4);
      vblank(1'b0);
      check_eq("t2_pulse",      32'(pv_a),      32'd1);
      check_eq("t2_pulse_once", 32'(pv_a_next), 32'd0);
      check_eq("t2_xmin",       32'(xmin_a),    32'd5);
      check_eq("t2_xmax",       32'(xmax_a),    32'd5);
      check_eq("t2_ymin",       32'(ymin_a),    32'd2);
      check_eq("t2_ymax",       32'(ymax_a),    32'd2);
      check_eq("t2_cnt",        32'(cnt_a),     32'd1);
      check_eq("t2_md",         32'(md_a),      32'd1);
      check_eq("t2_b_md",       32'(md_b),      32'd0);
      check_eq("t2_b_cnt",      32'(cnt_b),     32'd1);

      // Tests 3/4: three pixels; instance b is below its threshold of 4
      clear_mask();
      mask[0][1] = 16'h0001;
      mask[3][6] = 16'h1234;
      mask[1][3] = 16'hffff;
      send_frame(8, 4);
      vblank(1'b1);
      check_eq("t3_xmin", 32'(xmin_a), 32'd1);
      check_eq("t3_xmax", 32'(xmax_a), 32'd6);
      check_eq("t3_ymin", 32'(ymin_a), 32'd0);
      check_eq("t3_ymax", 32'(ymax_a), 32'd3);
      check_eq("t3_cnt",  32'(cnt_a),  32'd3);
      check_eq("t4_pulse", 32'(pv_b),   32'd1);
      check_eq("t4_md",    32'(md_b),   32'd0);
      check_eq("t4_xmax",  32'(xmax_b), 32'd0);
      check_eq("t4_ymax",  32'(ymax_b), 32'd0);
      check_eq("t4_cnt",   32'(cnt_b),  32'd3);

      // Test 5: href noise during that vblank must not count or advance rows
      clear_mask();
      mask[0][2] = 16'h0010;
      send_frame(8, 4);
      vblank(1'b0);
      check_eq("t5_cnt",  32'(cnt_a),  32'd1);
      check_eq("t5_xmin", 32'(xmin_a), 32'd2);
      check_eq("t5_ymin", 32'(ymin_a), 32'd0);
      check_eq("t5_ymax", 32'(ymax_a), 32'd0);

      // Test 6: reset mid-frame clears outputs at once and discards the next frame
      clear_mask();
      mask[0][4] = 16'h0002;
      mask[1][4] = 16'h0002;
      send_frame(8, 2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_xmin", 32'(xmin_a), 32'd0);
      check_eq("t6_rst_cnt",  32'(cnt_a),  32'd0);
      check_eq("t6_rst_md",   32'(md_a),   32'd0);
      idle(2);
      rst_n = 1'b1;
      send_frame(8, 2);
      vblank(1'b0);
      check_eq("t6_no_pulse", 32'(pv_a), 32'd0);
      clear_mask();
      mask[1][7] = 16'h0100;
      mask[2][0] = 16'h0100;
      send_frame(8, 4);
      vblank(1'b0);
      check_eq("t6_pulse", 32'(pv_a),   32'd1);
      check_eq("t6_xmin",  32'(xmin_a), 32'd0);
      check_eq("t6_xmax",  32'(xmax_a), 32'd7);
      check_eq("t6_ymin",  32'(ymin_a), 32'd1);
      check_eq("t6_ymax",  32'(ymax_a), 32'd2);
      check_eq("t6_cnt",   32'(cnt_a),  32'd2);

      // Test 7: 12-pixel lines, motion at column 10; 3-bit column saturates at 7
      clear_mask();
      mask[1][10] = 16'h0040;
      send_frame(12, 2);
      vblank(1'b0);
      check_eq("t7_a_xmax", 32'(xmax_a), 32'd10);
      check_eq("t7_c_pulse", 32'(pv_c),  32'd1);
      check_eq("t7_c_xmin", 32'(xmin_c), 32'd7);
      check_eq("t7_c_xmax", 32'(xmax_c), 32'd7);
      check_eq("t7_c_ymax", 32'(ymax_c), 32'd1);
      check_eq("t7_c_md",   32'(md_c),   32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
